// File: rtl/port_uart_tx_pkg.sv
// rtl/port_uart_tx_pkg.sv - shared constants and FSM state type for the UART output port
package port_uart_tx_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 434;
    localparam int DEFAULT_FIFO_DEPTH   = 4;
    localparam int DATA_BITS            = 8;
    localparam int BAUD_W               = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Width of an occupancy counter able to hold the value depth itself
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/port_fifo.sv
// rtl/port_fifo.sv - small synchronous FIFO with occupancy count
module port_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is refused even if a pop frees a slot this cycle
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // Storage array; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/port_uart_tx.sv
// rtl/port_uart_tx.sv - memory-mapped output port serialising bytes as 8N1 UART frames
module port_uart_tx
    import port_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        WriteEnable,
    input  logic [31:0] WriteData,
    output logic        Full,
    output logic        Busy,
    output logic        Overflow,
    output logic        TxSerial
);

    localparam int               CNT_W     = count_width(FIFO_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_t               state;
    tx_state_t               state_next;
    logic [BAUD_W-1:0]       baud_cnt;
    logic [BAUD_W-1:0]       baud_next;
    logic [2:0]              bit_idx;
    logic [2:0]              bit_next;
    logic [DATA_BITS-1:0]    shreg;
    logic [DATA_BITS-1:0]    shreg_next;
    logic                    tx_reg;
    logic                    tx_next;
    logic                    baud_expired;

    logic                    fifo_pop;
    logic [DATA_BITS-1:0]    fifo_dout;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [CNT_W-1:0]        fifo_count;

    logic                    unused_upper_bits;
    assign unused_upper_bits = ^WriteData[31:8];

    port_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (WriteEnable),
        .push_data (WriteData[7:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign baud_expired = (baud_cnt == BAUD_LAST);
    assign Full         = fifo_full;
    assign Busy         = (state != IDLE) || (fifo_count != '0);
    assign TxSerial     = tx_reg;

    // Sticky overflow: any store arriving while the FIFO is full is lost
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Overflow <= 1'b0;
        end else if (WriteEnable && fifo_full) begin
            Overflow <= 1'b1;
        end
    end

    // Transmitter state, baud timing, shift register and registered line
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            tx_reg   <= 1'b1;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_idx  <= bit_next;
            shreg    <= shreg_next;
            tx_reg   <= tx_next;
        end
    end

    // Next-state logic; the line value is computed for the state being entered
    // so TxSerial changes on the same edge as the state
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt + BAUD_W'(1);
        bit_next   = bit_idx;
        shreg_next = shreg;
        tx_next    = tx_reg;
        fifo_pop   = 1'b0;
        case (state)
            IDLE: begin
                baud_next = '0;
                tx_next   = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shreg_next = fifo_dout;
                    bit_next   = '0;
                    state_next = START;
                    tx_next    = 1'b0;
                end
            end
            START: begin
                if (baud_expired) begin
                    baud_next  = '0;
                    state_next = DATA;
                    tx_next    = shreg[0];
                end
            end
            DATA: begin
                if (baud_expired) begin
                    baud_next = '0;
                    if (bit_idx == 3'd7) begin
                        bit_next   = '0;
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        bit_next   = bit_idx + 3'd1;
                        shreg_next = {1'b0, shreg[DATA_BITS-1:1]};
                        tx_next    = shreg[1];
                    end
                end
            end
            STOP: begin
                if (baud_expired) begin
                    baud_next = '0;
                    // Chain straight into the next frame when a byte is waiting
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        shreg_next = fifo_dout;
                        bit_next   = '0;
                        state_next = START;
                        tx_next    = 1'b0;
                    end else begin
                        state_next = IDLE;
                        tx_next    = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                baud_next  = '0;
                tx_next    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_port_uart_tx.sv
// tb/tb_port_uart_tx.sv - randomized self-checking bench for port_uart_tx
module tb_port_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        WriteEnable = 1'b0;
    logic [31:0] WriteData = '0;
    logic        Full;
    logic        Busy;
    logic        Overflow;
    logic        TxSerial;

    int total = 0;
    int bad   = 0;

    // Reference: queued bytes plus the frame currently on the line,
    // described by its byte and the number of cycles since it started
    logic [7:0] mq[$];
    bit         m_active = 1'b0;
    int         m_off = 0;
    logic [7:0] m_cur = '0;
    bit         m_ovf = 1'b0;

    always #5 clk = ~clk;

    port_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .WriteEnable (WriteEnable),
        .WriteData   (WriteData),
        .Full        (Full),
        .Busy        (Busy),
        .Overflow    (Overflow),
        .TxSerial    (TxSerial)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Line level of an 8N1 frame, from the offset into the frame
    function automatic logic m_line();
        int b;
        if (!m_active) return 1'b1;
        b = m_off / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_cur[b-1];
        return 1'b1;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_active = 1'b0;
        m_off    = 0;
        m_ovf    = 1'b0;
    endtask

    // Advance the reference across one rising edge
    task automatic model_edge(input bit we, input logic [31:0] d);
        bit full_pre;
        full_pre = (mq.size() == DEPTH);
        if (m_active) begin
            m_off++;
            if (m_off == FRAME) m_active = 1'b0;
        end
        if (!m_active && mq.size() > 0) begin
            m_cur    = mq.pop_front();
            m_active = 1'b1;
            m_off    = 0;
        end
        if (we) begin
            if (full_pre) m_ovf = 1'b1;
            else          mq.push_back(d[7:0]);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".tx"},   {31'd0, TxSerial}, {31'd0, m_line()});
        check({tag, ".busy"}, {31'd0, Busy},     {31'd0, (m_active || mq.size() > 0)});
        check({tag, ".full"}, {31'd0, Full},     {31'd0, (mq.size() == DEPTH)});
        check({tag, ".ovf"},  {31'd0, Overflow}, {31'd0, m_ovf});
    endtask

    // One clock: drive inputs after the falling edge, check at the next falling edge
    task automatic step(input bit we, input logic [31:0] d, input string tag);
        WriteEnable = we;
        WriteData   = d;
        model_edge(we, d);
        @(posedge clk);
        @(negedge clk);
        WriteEnable = 1'b0;
        check_outputs(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, tag);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_outputs("rst");
        reset = 1'b1;
    endtask

    initial begin
        int guard;
        @(negedge clk);
        @(negedge clk);
        check_outputs("por");
        reset = 1'b1;
        idle(3, "idle0");

        // Single frame, then a frame whose upper data bits must be ignored
        step(1'b1, 32'h0000_00A5, "a5");
        idle(FRAME + 4, "a5_line");
        step(1'b1, 32'hDEAD_BE3C, "3c");
        idle(FRAME + 4, "3c_line");

        // Five back-to-back writes fill the FIFO exactly
        for (int i = 1; i <= 5; i++) step(1'b1, 32'(i), "burst5");
        check("burst5_full", {31'd0, Full}, 32'd1);
        idle(5 * FRAME + 4, "burst5_line");

        // Six back-to-back writes: the sixth is dropped, Overflow sticks
        for (int i = 0; i < 6; i++) step(1'b1, 32'h40 + 32'(i), "burst6");
        idle(5 * FRAME + 4, "burst6_line");
        check("ovf_sticky", {31'd0, Overflow}, 32'd1);

        // Reset during data bit 3 with the FIFO full
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 32'h96 + 32'(i), "pre_rst");
        guard = 0;
        while (!(m_active && (m_off / CPB) == 4) && guard < 200) begin
            step(1'b0, 32'd0, "to_bit3");
            guard++;
        end
        check("reach_bit3", {31'd0, (guard < 200)}, 32'd1);
        #1 reset = 1'b0;
        #1;
        check("arst_tx",   {31'd0, TxSerial}, 32'd1);
        check("arst_busy", {31'd0, Busy},     32'd0);
        check("arst_full", {31'd0, Full},     32'd0);
        check("arst_ovf",  {31'd0, Overflow}, 32'd0);
        model_reset();
        #1 reset = 1'b1;
        idle(2 * FRAME, "post_rst");

        // Write landing on the STOP-expiry pop while one byte is queued
        step(1'b1, 32'h11, "chain");
        step(1'b1, 32'h22, "chain");
        guard = 0;
        while (!(m_active && m_off == FRAME - 1) && guard < 200) begin
            step(1'b0, 32'd0, "to_stop_end");
            guard++;
        end
        check("reach_stop_end", {31'd0, (guard < 200)}, 32'd1);
        step(1'b1, 32'h33, "chain_pop_push");
        check("chain_count1", {31'd0, Busy}, 32'd1);
        idle(3 * FRAME, "chain_line");

        // Randomized traffic with occasional bursts
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit we;
            if ((i / 200) % 3 == 2) we = ($urandom_range(0, 2) == 0);
            else                    we = ($urandom_range(0, 39) == 0);
            step(we, $urandom, "rand");
        end
        idle(DEPTH * FRAME + FRAME + 4, "drain");
        check("drain_busy", {31'd0, Busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
